legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
- Multicycle control unit that sequences the LEGv8 64-bit datapath core (register file, ALU, program counter, instruction register, status register, RAM, tri-state buses).
- Each cycle it drives the full control word (selects, enables, FS, SA/SB/DA, k) from the latched instruction and the status flags.
- Instruction classes: R-type, immediate ALU, load, store, branch, compare-and-branch and register branch.
- Sits beside the datapath core at CPU top level; it is the only driver of the datapath control inputs.

Parameters:
- RESET_STATE_IDLE, 1, 1 = leave reset in IDLE and wait for run; 0 = go straight to FETCH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; when high, the controller leaves IDLE and keeps executing
- IR_out  in  32  instruction register contents
- status  in  4  registered flags; bit 0 Z, bit 1 N, bit 2 C, bit 3 V
- w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, PC_sel, B_Sel, add_tri_sel  out  1 each  datapath controls
- data_tri_sel  out  2  data-bus source: 0 ALU, 1 regB, 2 PC, 3 memory
- PC_FS  out  2  0 hold, 1 PC+4, 2 PC+(in<<2), 3 load in
- FS  out  5  ALU function
- size  out  2  memory access size; always 2'b11 (doubleword)
- SA, SB, DA  out  5 each  register addresses
- k  out  32  constant/immediate
- state  out  3  current state, for debug
- halted  out  1  high in HALT

Behaviour:
- Reset: state=IDLE (or FETCH when RESET_STATE_IDLE=0); every control output is 0; halted=0. Asserting reset mid-instruction aborts it immediately; no further write enables are asserted.
- States: IDLE, FETCH, DECODE, EXEC, MEM, BRCHK, HALT.
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH:
  - add_tri_sel=1 (PC addresses memory), mem_cs=1, data_tri_sel=3, IR_load=1, PC_FS=1.
  - Goes to DECODE.
- DECODE: outputs 0. Classifies IR_out; goes to EXEC, or to HALT on an illegal opcode.
- EXEC, by class:
  - R-type ADD/SUB/AND/ORR (opcodes 10001011000/11001011000/10001010000/10101010000): SA=Rn[9:5], SB=Rm[20:16], DA=Rd[4:0], B_Sel=0, data_tri_sel=0, w_reg=(Rd!=31).
  - ADDI/SUBI (1001000100/1101000100): as R-type, but B_Sel=1 and k=zero-extended imm12[21:10].
  - LDUR (11111000010):
    - EXEC: SA=Rn, B_Sel=1, k=sign-extended imm9[20:12], FS=ADD, add_tri_sel=0, mem_cs=1, data_tri_sel=3, DA=Rt, w_reg=0.
    - MEM: same controls with w_reg=(Rt!=31).
  - STUR (11111000000): same address controls as LDUR EXEC, plus SB=Rt, data_tri_sel=1, mem_write_en=1. Single cycle.
  - B (000101):
    - PC_sel=1, PC_FS=2, k=sext(imm26)-1.
    - The -1 compensates for the FETCH increment, so the target is instr_addr + 4*imm26.
  - CBZ/CBNZ (10110100/10110101):
    - EXEC: SA=Rt, B_Sel=1, k=0, FS=ADD, status_load=1. Goes to BRCHK.
    - BRCHK: taken when Z==1 (CBZ) or Z==0 (CBNZ).
    - Taken: PC_sel=1, PC_FS=2, k=sext(imm19[23:5])-1. Not taken: PC_FS=0.
    - CBZ/CBNZ overwrite the status register.
  - BR (11010110000): SA=Rn, PC_sel=0, PC_FS=3.
- FS encoding: {invA, invB, op[2:0]}, op 000 AND, 001 OR, 010 ADD. SUB = 01010 with C0=1; C0=0 otherwise.
- Sequencing: after EXEC, MEM or BRCHK, go to FETCH if run=1, else IDLE. Dropping run never stops an instruction mid-flight.
- HALT: sticky until reset; halted=1; all other outputs 0.
- Per-class cycle counts including FETCH+DECODE: ALU/STUR/B/BR 3, LDUR/CBZ/CBNZ 4.

Optional Feature:
- Macro: LEGV8_FLAG_BRANCH_EN.
- Defined:
  - ADDS (10101011000) and SUBS (11101011000) behave as ADD/SUB with status_load=1.
  - B.cond (01010100, cond[3:0]): EXEC goes to BRCHK without touching status.
  - Supported conditions: EQ 0000, NE 0001, LT 1011 (N!=V), GE 1010 (N==V).
  - Taken branch uses k=sext(imm19)-1. Any other cond is not taken.
- Undefined: these opcodes are illegal and go to HALT.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - FS constants (FS_AND, FS_OR, FS_ADD, FS_SUB);
  - PC_FS constants (PC_HOLD, PC_INC, PC_REL, PC_LOAD);
  - data_tri_sel constants;
  - status bit indices.
- Sub-module legv8_instr_decode: purely combinational. IR_out in; class, field extraction and immediate sign-extension out. The FSM instantiates it once.

Test Plan:
- Reset low mid-EXEC of ADD → all outputs 0 on the same cycle; state=IDLE after release; no w_reg pulse.
- run=1, IR=ADD X3,X1,X2 → FETCH(IR_load=1, PC_FS=1), DECODE, EXEC(SA=1, SB=2, DA=3, FS=00010, w_reg=1), then FETCH.
- SUB X31,X1,X2 → FS=01010, C0=1, w_reg=0.
- LDUR X5,[X2,#-8] → EXEC k=0xFFFFFFF8, w_reg=0; MEM w_reg=1, DA=5, data_tri_sel=3.
- CBZ X4,#+3 with status Z=1 after EXEC → BRCHK PC_sel=1, PC_FS=2, k=2. With Z=0 → PC_FS=0.
- IR=0xFFFFFFFF → HALT; halted=1 persists with run=1 until reset. With LEGV8_FLAG_BRANCH_EN: B.NE taken when Z=0, k=sext(imm19)-1.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// ============================================================================
// legv8_ctrl_pkg
// Shared types and encodings for the LEGv8 multicycle control unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_BRCHK  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_RTYPE, C_IMM, C_LDUR, C_STUR,
        C_B, C_CBZ, C_CBNZ, C_BR, C_BCOND
    } iclass_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // ALU function word is {invA, invB, op[2:0]}
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00001;
    localparam logic [4:0] FS_ADD = 5'b00010;
    localparam logic [4:0] FS_SUB = 5'b01010;

    localparam logic [1:0] PC_HOLD = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_REL  = 2'd2;
    localparam logic [1:0] PC_LOAD = 2'd3;

    localparam logic [1:0] DT_ALU  = 2'd0;
    localparam logic [1:0] DT_REGB = 2'd1;
    localparam logic [1:0] DT_PC   = 2'd2;
    localparam logic [1:0] DT_MEM  = 2'd3;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;

    typedef struct packed {
        iclass_t     cls;
        logic [4:0]  fs;
        logic        c0;
        logic        set_flags;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [3:0]  cond;
        logic [31:0] imm12_zx;
        logic [31:0] imm9_sx;
        logic [31:0] br26_k;
        logic [31:0] br19_k;
    } decode_t;

    typedef struct packed {
        logic        w_reg;
        logic        c0;
        logic        mem_cs;
        logic        mem_write_en;
        logic        ir_load;
        logic        status_load;
        logic        pc_sel;
        logic        b_sel;
        logic        add_tri_sel;
        logic [1:0]  data_tri_sel;
        logic [1:0]  pc_fs;
        logic [4:0]  fs;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [31:0] k;
    } ctrl_t;

    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c              = '0;
        c.add_tri_sel  = 1'b1;
        c.mem_cs       = 1'b1;
        c.data_tri_sel = DT_MEM;
        c.ir_load      = 1'b1;
        c.pc_fs        = PC_INC;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/legv8_instr_decode.sv
// ============================================================================
// legv8_instr_decode
// Combinational instruction classifier, field extractor and immediate builder.
// Optional B.cond / ADDS / SUBS support under LEGV8_FLAG_BRANCH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module legv8_instr_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output decode_t     o_dec
);

    always_comb begin
        o_dec           = '0;
        o_dec.cls       = C_ILLEGAL;
        o_dec.fs        = FS_AND;
        o_dec.rd        = i_ir[4:0];
        o_dec.rn        = i_ir[9:5];
        o_dec.rm        = i_ir[20:16];
        o_dec.cond      = i_ir[3:0];
        o_dec.imm12_zx  = {20'd0, i_ir[21:10]};
        o_dec.imm9_sx   = {{23{i_ir[20]}}, i_ir[20:12]};
        // Branch offsets absorb the PC+4 already applied during FETCH
        o_dec.br26_k    = {{6{i_ir[25]}}, i_ir[25:0]} - 32'd1;
        o_dec.br19_k    = {{13{i_ir[23]}}, i_ir[23:5]} - 32'd1;

        if (i_ir[31:26] == OP_B) begin
            o_dec.cls = C_B;
        end else if (i_ir[31:24] == OP_CBZ) begin
            o_dec.cls = C_CBZ;
        end else if (i_ir[31:24] == OP_CBNZ) begin
            o_dec.cls = C_CBNZ;
`ifdef LEGV8_FLAG_BRANCH_EN
        end else if (i_ir[31:24] == OP_BCOND) begin
            o_dec.cls = C_BCOND;
`endif
        end else if (i_ir[31:22] == OP_ADDI) begin
            o_dec.cls = C_IMM;
            o_dec.fs  = FS_ADD;
        end else if (i_ir[31:22] == OP_SUBI) begin
            o_dec.cls = C_IMM;
            o_dec.fs  = FS_SUB;
            o_dec.c0  = 1'b1;
        end else begin
            case (i_ir[31:21])
                OP_ADD:  begin o_dec.cls = C_RTYPE; o_dec.fs = FS_ADD; end
                OP_SUB:  begin o_dec.cls = C_RTYPE; o_dec.fs = FS_SUB; o_dec.c0 = 1'b1; end
                OP_AND:  begin o_dec.cls = C_RTYPE; o_dec.fs = FS_AND; end
                OP_ORR:  begin o_dec.cls = C_RTYPE; o_dec.fs = FS_OR;  end
`ifdef LEGV8_FLAG_BRANCH_EN
                OP_ADDS: begin o_dec.cls = C_RTYPE; o_dec.fs = FS_ADD; o_dec.set_flags = 1'b1; end
                OP_SUBS: begin
                    o_dec.cls       = C_RTYPE;
                    o_dec.fs        = FS_SUB;
                    o_dec.c0        = 1'b1;
                    o_dec.set_flags = 1'b1;
                end
`endif
                OP_LDUR: o_dec.cls = C_LDUR;
                OP_STUR: o_dec.cls = C_STUR;
                OP_BR:   o_dec.cls = C_BR;
                default: o_dec.cls = C_ILLEGAL;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/legv8_multicycle_ctrl.sv
// ============================================================================
// legv8_multicycle_ctrl
// Multicycle FSM driving the LEGv8 datapath control word; optional flag-based
// branches (B.cond, ADDS, SUBS) enabled by LEGV8_FLAG_BRANCH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_IDLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR_out,
    input  logic [3:0]  status,
    output logic        w_reg,
    output logic        C0,
    output logic        mem_cs,
    output logic        mem_write_en,
    output logic        IR_load,
    output logic        status_load,
    output logic        PC_sel,
    output logic        B_Sel,
    output logic        add_tri_sel,
    output logic [1:0]  data_tri_sel,
    output logic [1:0]  PC_FS,
    output logic [4:0]  FS,
    output logic [1:0]  size,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic [31:0] k,
    output logic [2:0]  state,
    output logic        halted
);

    decode_t w_dec;
    ctrl_t   w_exec;
    ctrl_t   w_mem;
    ctrl_t   w_brchk;
    ctrl_t   w_after;
    logic    w_taken;
    logic    w_not_taken;
    logic    w_unused;

    state_t  r_state;
    ctrl_t   r_ctrl;
    logic    r_halted;

    legv8_instr_decode u_decode (
        .i_ir  (IR_out),
        .o_dec (w_dec)
    );

    always_comb begin
        w_exec = '0;
        case (w_dec.cls)
            C_RTYPE, C_IMM: begin
                w_exec.sa           = w_dec.rn;
                w_exec.sb           = w_dec.rm;
                w_exec.da           = w_dec.rd;
                w_exec.fs           = w_dec.fs;
                w_exec.c0           = w_dec.c0;
                w_exec.data_tri_sel = DT_ALU;
                w_exec.w_reg        = (w_dec.rd != 5'd31);
                w_exec.status_load  = w_dec.set_flags;
                if (w_dec.cls == C_IMM) begin
                    w_exec.b_sel = 1'b1;
                    w_exec.k     = w_dec.imm12_zx;
                end
            end
            C_LDUR, C_STUR: begin
                w_exec.sa     = w_dec.rn;
                w_exec.b_sel  = 1'b1;
                w_exec.k      = w_dec.imm9_sx;
                w_exec.fs     = FS_ADD;
                w_exec.mem_cs = 1'b1;
                if (w_dec.cls == C_LDUR) begin
                    w_exec.data_tri_sel = DT_MEM;
                    w_exec.da           = w_dec.rd;
                end else begin
                    w_exec.sb           = w_dec.rd;
                    w_exec.data_tri_sel = DT_REGB;
                    w_exec.mem_write_en = 1'b1;
                end
            end
            C_B: begin
                w_exec.pc_sel = 1'b1;
                w_exec.pc_fs  = PC_REL;
                w_exec.k      = w_dec.br26_k;
            end
            C_CBZ, C_CBNZ: begin
                // Rt + 0 through the ALU so the status register reflects Rt == 0
                w_exec.sa          = w_dec.rd;
                w_exec.b_sel       = 1'b1;
                w_exec.fs          = FS_ADD;
                w_exec.status_load = 1'b1;
            end
            C_BR: begin
                w_exec.sa    = w_dec.rn;
                w_exec.pc_fs = PC_LOAD;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_mem       = w_exec;
        w_mem.w_reg = (w_dec.rd != 5'd31);
    end

    always_comb begin
        w_brchk        = '0;
        w_brchk.pc_sel = 1'b1;
        w_brchk.pc_fs  = PC_REL;
        w_brchk.k      = w_dec.br19_k;
    end

    assign w_after = run ? fetch_ctrl() : '0;

    // Flags are only valid once BRCHK is reached, so the decision is made here
    always_comb begin
        w_taken = 1'b0;
        case (w_dec.cls)
            C_CBZ:   w_taken = status[ST_Z];
            C_CBNZ:  w_taken = ~status[ST_Z];
            C_BCOND: begin
                case (w_dec.cond)
                    COND_EQ: w_taken = status[ST_Z];
                    COND_NE: w_taken = ~status[ST_Z];
                    COND_LT: w_taken = status[ST_N] ^ status[ST_V];
                    COND_GE: w_taken = ~(status[ST_N] ^ status[ST_V]);
                    default: w_taken = 1'b0;
                endcase
            end
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= RESET_STATE_IDLE ? S_IDLE : S_FETCH;
            r_ctrl   <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ctrl <= w_after;
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // Entering FETCH straight from reset needs one cycle to load the fetch word
                    if (!r_ctrl.ir_load) begin
                        r_ctrl <= fetch_ctrl();
                    end else begin
                        r_ctrl  <= '0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_dec.cls == C_ILLEGAL) begin
                        r_ctrl   <= '0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_ctrl  <= w_exec;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_dec.cls == C_LDUR) begin
                        r_ctrl  <= w_mem;
                        r_state <= S_MEM;
                    end else if (w_dec.cls == C_CBZ || w_dec.cls == C_CBNZ ||
                                 w_dec.cls == C_BCOND) begin
                        r_ctrl  <= w_brchk;
                        r_state <= S_BRCHK;
                    end else begin
                        r_ctrl  <= w_after;
                        r_state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_MEM, S_BRCHK: begin
                    r_ctrl  <= w_after;
                    r_state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    r_ctrl   <= '0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_ctrl  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_not_taken  = (r_state == S_BRCHK) && !w_taken;

    assign w_reg        = r_ctrl.w_reg;
    assign C0           = r_ctrl.c0;
    assign mem_cs       = r_ctrl.mem_cs;
    assign mem_write_en = r_ctrl.mem_write_en;
    assign IR_load      = r_ctrl.ir_load;
    assign status_load  = r_ctrl.status_load;
    assign PC_sel       = r_ctrl.pc_sel & ~w_not_taken;
    assign B_Sel        = r_ctrl.b_sel;
    assign add_tri_sel  = r_ctrl.add_tri_sel;
    assign data_tri_sel = r_ctrl.data_tri_sel;
    assign PC_FS        = w_not_taken ? PC_HOLD : r_ctrl.pc_fs;
    assign FS           = r_ctrl.fs;
    assign size         = 2'b11;
    assign SA           = r_ctrl.sa;
    assign SB           = r_ctrl.sb;
    assign DA           = r_ctrl.da;
    assign k            = r_ctrl.k;
    assign state        = r_state;
    assign halted       = r_halted;

    assign w_unused     = status[ST_C];

endmodule

`default_nettype wire

// File: tb/tb_legv8_multicycle_ctrl.sv
// ============================================================================
// tb_legv8_multicycle_ctrl
// Table-driven bench for the LEGv8 multicycle controller plus reset/HALT cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_legv8_multicycle_ctrl;
    import legv8_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] IR_out;
    logic [3:0]  status;
    logic        w_reg, C0, mem_cs, mem_write_en, IR_load, status_load;
    logic        PC_sel, B_Sel, add_tri_sel, halted;
    logic [1:0]  data_tri_sel, PC_FS, size;
    logic [4:0]  FS, SA, SB, DA;
    logic [31:0] k;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    legv8_multicycle_ctrl dut (
        .clock(clock), .reset(reset), .run(run), .IR_out(IR_out), .status(status),
        .w_reg(w_reg), .C0(C0), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
        .IR_load(IR_load), .status_load(status_load), .PC_sel(PC_sel), .B_Sel(B_Sel),
        .add_tri_sel(add_tri_sel), .data_tri_sel(data_tri_sel), .PC_FS(PC_FS), .FS(FS),
        .size(size), .SA(SA), .SB(SB), .DA(DA), .k(k), .state(state), .halted(halted)
    );

    typedef struct packed {
        logic        w_reg, c0, mem_cs, mem_we, ir_load, status_load, pc_sel, b_sel, add_tri;
        logic [1:0]  dts, pcfs;
        logic [4:0]  fs, sa, sb, da;
        logic [31:0] k;
    } cw_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [3:0]  st;
        cw_t         w1;
        bit          two;
        logic [2:0]  st2;
        cw_t         w2;
    } vec_t;

    vec_t vecs[$];
    cw_t  c_fetch;
    cw_t  c_zero;

    function automatic cw_t mk(input logic wr, c0, cs, we, sl, pcsel, bsel,
                               input logic [1:0] dts, pcfs,
                               input logic [4:0] fs, sa, sb, da,
                               input logic [31:0] kk);
        return '{w_reg:wr, c0:c0, mem_cs:cs, mem_we:we, ir_load:1'b0, status_load:sl,
                 pc_sel:pcsel, b_sel:bsel, add_tri:1'b0, dts:dts, pcfs:pcfs,
                 fs:fs, sa:sa, sb:sb, da:da, k:kk};
    endfunction

    function automatic cw_t obs();
        return '{w_reg:w_reg, c0:C0, mem_cs:mem_cs, mem_we:mem_write_en, ir_load:IR_load,
                 status_load:status_load, pc_sel:PC_sel, b_sel:B_Sel, add_tri:add_tri_sel,
                 dts:data_tri_sel, pcfs:PC_FS, fs:FS, sa:SA, sb:SB, da:DA, k:k};
    endfunction

    function automatic vec_t mkv(input string nm, input logic [31:0] ir, input logic [3:0] st,
                                 input cw_t w1, input bit two, input logic [2:0] st2,
                                 input cw_t w2);
        vec_t v;
        v.name = nm; v.ir = ir; v.st = st; v.w1 = w1; v.two = two; v.st2 = st2; v.w2 = w2;
        return v;
    endfunction

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn, rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                          input logic [4:0] rn, rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                           input logic [4:0] rt);
        return {op, imm, rt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic chk_cw(input string nm, input cw_t got, input cw_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // run is dropped during EXEC, so every vector also proves the instruction completes
    task automatic run_vec(input vec_t v);
        IR_out = v.ir;
        status = v.st;
        run    = 1'b1;
        @(negedge clock);
        chk({v.name, " fetch state"}, state, S_FETCH);
        chk_cw({v.name, " fetch word"}, obs(), c_fetch);
        @(negedge clock);
        chk({v.name, " decode state"}, state, S_DECODE);
        chk_cw({v.name, " decode word"}, obs(), c_zero);
        @(negedge clock);
        chk({v.name, " exec state"}, state, S_EXEC);
        chk_cw({v.name, " exec word"}, obs(), v.w1);
        run = 1'b0;
        if (v.two) begin
            @(negedge clock);
            chk({v.name, " 2nd state"}, state, v.st2);
            chk_cw({v.name, " 2nd word"}, obs(), v.w2);
        end
        @(negedge clock);
        chk({v.name, " end state"}, state, S_IDLE);
        chk_cw({v.name, " end word"}, obs(), c_zero);
    endtask

    task automatic expect_halt(input string nm, input logic [31:0] ir);
        IR_out = ir;
        run    = 1'b1;
        repeat (3) @(negedge clock);
        chk({nm, " halt state"}, state, S_HALT);
        chk({nm, " halted"}, halted, 1);
        chk_cw({nm, " halt word"}, obs(), c_zero);
        repeat (5) @(negedge clock);
        chk({nm, " halt sticky"}, {state, halted}, {S_HALT, 1'b1});
        reset = 1'b0;
        #1;
        chk({nm, " reset clears halt"}, {state, halted}, {S_IDLE, 1'b0});
        run = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        c_zero  = '0;
        c_fetch = '0;
        c_fetch.ir_load = 1'b1; c_fetch.mem_cs = 1'b1; c_fetch.add_tri = 1'b1;
        c_fetch.dts     = 2'd3; c_fetch.pcfs   = 2'd1;

        vecs.push_back(mkv("ADD X3,X1,X2", enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 4'h0,
            mk(1,0,0,0,0,0,0, 2'd0,2'd0, 5'b00010, 5'd1,5'd2,5'd3, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("SUB X31,X1,X2", enc_r(11'b11001011000, 5'd2, 5'd1, 5'd31), 4'h0,
            mk(0,1,0,0,0,0,0, 2'd0,2'd0, 5'b01010, 5'd1,5'd2,5'd31, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("AND X7,X8,X9", enc_r(11'b10001010000, 5'd9, 5'd8, 5'd7), 4'h0,
            mk(1,0,0,0,0,0,0, 2'd0,2'd0, 5'b00000, 5'd8,5'd9,5'd7, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("ORR X10,X11,X12", enc_r(11'b10101010000, 5'd12, 5'd11, 5'd10), 4'h0,
            mk(1,0,0,0,0,0,0, 2'd0,2'd0, 5'b00001, 5'd11,5'd12,5'd10, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("ADDI X4,X5,#ABC", enc_i(10'b1001000100, 12'hABC, 5'd5, 5'd4), 4'h0,
            mk(1,0,0,0,0,0,1, 2'd0,2'd0, 5'b00010, 5'd5,5'd10,5'd4, 32'h0000_0ABC), 0, 3'd0, '0));
        vecs.push_back(mkv("SUBI X6,X6,#1", enc_i(10'b1101000100, 12'h001, 5'd6, 5'd6), 4'h0,
            mk(1,1,0,0,0,0,1, 2'd0,2'd0, 5'b01010, 5'd6,5'd0,5'd6, 32'd1), 0, 3'd0, '0));
        vecs.push_back(mkv("LDUR X5,[X2,#-8]", enc_d(11'b11111000010, 9'h1F8, 5'd2, 5'd5), 4'h0,
            mk(0,0,1,0,0,0,1, 2'd3,2'd0, 5'b00010, 5'd2,5'd0,5'd5, 32'hFFFF_FFF8), 1, S_MEM,
            mk(1,0,1,0,0,0,1, 2'd3,2'd0, 5'b00010, 5'd2,5'd0,5'd5, 32'hFFFF_FFF8)));
        vecs.push_back(mkv("LDUR X31,[X1,#0]", enc_d(11'b11111000010, 9'h000, 5'd1, 5'd31), 4'h0,
            mk(0,0,1,0,0,0,1, 2'd3,2'd0, 5'b00010, 5'd1,5'd0,5'd31, 32'd0), 1, S_MEM,
            mk(0,0,1,0,0,0,1, 2'd3,2'd0, 5'b00010, 5'd1,5'd0,5'd31, 32'd0)));
        vecs.push_back(mkv("STUR X7,[X3,#16]", enc_d(11'b11111000000, 9'd16, 5'd3, 5'd7), 4'h0,
            mk(0,0,1,1,0,0,1, 2'd1,2'd0, 5'b00010, 5'd3,5'd7,5'd0, 32'd16), 0, 3'd0, '0));
        vecs.push_back(mkv("B #-2", {6'b000101, 26'h3FF_FFFE}, 4'h0,
            mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'b00000, 5'd0,5'd0,5'd0, 32'hFFFF_FFFD), 0, 3'd0, '0));
        vecs.push_back(mkv("CBZ X4,#3 Z=1", enc_cb(8'b10110100, 19'd3, 5'd4), 4'b0001,
            mk(0,0,0,0,1,0,1, 2'd0,2'd0, 5'b00010, 5'd4,5'd0,5'd0, 32'd0), 1, S_BRCHK,
            mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'b00000, 5'd0,5'd0,5'd0, 32'd2)));
        vecs.push_back(mkv("CBZ X4,#3 Z=0", enc_cb(8'b10110100, 19'd3, 5'd4), 4'b0000,
            mk(0,0,0,0,1,0,1, 2'd0,2'd0, 5'b00010, 5'd4,5'd0,5'd0, 32'd0), 1, S_BRCHK,
            mk(0,0,0,0,0,0,0, 2'd0,2'd0, 5'b00000, 5'd0,5'd0,5'd0, 32'd2)));
        vecs.push_back(mkv("CBNZ X9,#-1 Z=0", enc_cb(8'b10110101, 19'h7FFFF, 5'd9), 4'b0000,
            mk(0,0,0,0,1,0,1, 2'd0,2'd0, 5'b00010, 5'd9,5'd0,5'd0, 32'd0), 1, S_BRCHK,
            mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'b00000, 5'd0,5'd0,5'd0, 32'hFFFF_FFFE)));
        vecs.push_back(mkv("CBNZ X9,#-1 Z=1", enc_cb(8'b10110101, 19'h7FFFF, 5'd9), 4'b0001,
            mk(0,0,0,0,1,0,1, 2'd0,2'd0, 5'b00010, 5'd9,5'd0,5'd0, 32'd0), 1, S_BRCHK,
            mk(0,0,0,0,0,0,0, 2'd0,2'd0, 5'b00000, 5'd0,5'd0,5'd0, 32'hFFFF_FFFE)));
        vecs.push_back(mkv("BR X30", {11'b11010110000, 5'd31, 6'd0, 5'd30, 5'd0}, 4'h0,
            mk(0,0,0,0,0,0,0, 2'd0,2'd3, 5'b00000, 5'd30,5'd0,5'd0, 32'd0), 0, 3'd0, '0));
`ifdef LEGV8_FLAG_BRANCH_EN
        vecs.push_back(mkv("ADDS X1,X2,X3", enc_r(11'b10101011000, 5'd3, 5'd2, 5'd1), 4'h0,
            mk(1,0,0,0,1,0,0, 2'd0,2'd0, 5'b00010, 5'd2,5'd3,5'd1, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("SUBS X31,X2,X3", enc_r(11'b11101011000, 5'd3, 5'd2, 5'd31), 4'h0,
            mk(0,1,0,0,1,0,0, 2'd0,2'd0, 5'b01010, 5'd2,5'd3,5'd31, 32'd0), 0, 3'd0, '0));
        vecs.push_back(mkv("B.NE #5 Z=0", {8'b01010100, 19'd5, 1'b0, 4'b0001}, 4'b0000,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'd0, 5'd0,5'd0,5'd0, 32'd4)));
        vecs.push_back(mkv("B.NE #5 Z=1", {8'b01010100, 19'd5, 1'b0, 4'b0001}, 4'b0001,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,0,0, 2'd0,2'd0, 5'd0, 5'd0,5'd0,5'd0, 32'd4)));
        vecs.push_back(mkv("B.EQ #5 Z=1", {8'b01010100, 19'd5, 1'b0, 4'b0000}, 4'b0001,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'd0, 5'd0,5'd0,5'd0, 32'd4)));
        vecs.push_back(mkv("B.LT #-4 N=1 V=0", {8'b01010100, 19'h7FFFC, 1'b0, 4'b1011}, 4'b0010,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,1,0, 2'd0,2'd2, 5'd0, 5'd0,5'd0,5'd0, 32'hFFFF_FFFB)));
        vecs.push_back(mkv("B.GE #-4 N=1 V=0", {8'b01010100, 19'h7FFFC, 1'b0, 4'b1010}, 4'b0010,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,0,0, 2'd0,2'd0, 5'd0, 5'd0,5'd0,5'd0, 32'hFFFF_FFFB)));
        vecs.push_back(mkv("B.GT unsupported", {8'b01010100, 19'd5, 1'b0, 4'b1100}, 4'b0000,
            c_zero, 1, S_BRCHK, mk(0,0,0,0,0,0,0, 2'd0,2'd0, 5'd0, 5'd0,5'd0,5'd0, 32'd4)));
`endif

        reset  = 1'b0;
        run    = 1'b0;
        IR_out = 32'd0;
        status = 4'd0;
        #12;
        chk("reset state", state, S_IDLE);
        chk_cw("reset word", obs(), c_zero);
        chk("reset halted", halted, 0);
        chk("size constant", size, 3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle without run", state, S_IDLE);

        foreach (vecs[i]) run_vec(vecs[i]);

        // run held high: EXEC goes straight back to FETCH
        IR_out = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
        run    = 1'b1;
        repeat (4) @(negedge clock);
        chk("run held refetch", {state, IR_load}, {S_FETCH, 1'b1});
        run = 1'b0;
        repeat (3) @(negedge clock);
        chk("run dropped to idle", state, S_IDLE);

        // reset mid-EXEC aborts with no write enable
        run = 1'b1;
        repeat (3) @(negedge clock);
        chk("pre-reset exec w_reg", {state, w_reg}, {S_EXEC, 1'b1});
        #1 reset = 1'b0;
        #1;
        chk_cw("async reset word", obs(), c_zero);
        chk("async reset state", state, S_IDLE);
        run = 1'b0;
        @(negedge clock);
        chk("reset held w_reg", w_reg, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post-reset idle", {state, w_reg}, {S_IDLE, 1'b0});

        expect_halt("illegal FFFFFFFF", 32'hFFFF_FFFF);
`ifndef LEGV8_FLAG_BRANCH_EN
        expect_halt("ADDS disabled", enc_r(11'b10101011000, 5'd3, 5'd2, 5'd1));
        expect_halt("B.NE disabled", {8'b01010100, 19'd5, 1'b0, 4'b0001});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
